// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of client request/data signals and the TX FIFO write-port pins
// that the write arbiter sits between.
interface fifo_wr_arbiter_if #(
    parameter int B     = 8,
    parameter int LEN_W = 4
);
    // client side
    logic             req0;
    logic             req1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [B-1:0]     data0;
    logic [B-1:0]     data1;
    logic             valid0;
    logic             valid1;
    logic             ready0;
    logic             ready1;
    logic [1:0]       gnt;
    logic             busy;
    // FIFO side
    logic             fifo_full;
    logic             fifo_wr;
    logic [B-1:0]     fifo_w_data;

    // arbiter view
    modport slave (
        input  req0, req1, len0, len1, data0, data1, valid0, valid1, fifo_full,
        output ready0, ready1, gnt, busy, fifo_wr, fifo_w_data
    );

    // clients + FIFO view
    modport master (
        output req0, req1, len0, len1, data0, data1, valid0, valid1, fifo_full,
        input  ready0, ready1, gnt, busy, fifo_wr, fifo_w_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: two byte-stream clients share one TX FIFO write
// port. A grant is locked for a whole declared burst, and every byte is
// gated against fifo_full so nothing is dropped.
module fifo_wr_arbiter #(
    parameter int B     = 8,
    parameter int LEN_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    fifo_wr_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       gnt_q,   gnt_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic             last_q,  last_d;

    logic             ready0;
    logic             ready1;
    logic             wr;
    logic             sel;
    logic             pick;
    logic [LEN_W-1:0] len_pick;

    // Write-port gating: only the granted client sees ready, and never while full
    always_comb begin
        ready0 = gnt_q[0] & ~bus.fifo_full;
        ready1 = gnt_q[1] & ~bus.fifo_full;
        wr     = (ready0 & bus.valid0) | (ready1 & bus.valid1);
        sel    = gnt_q[1];
        if (gnt_q[0]) begin
            bus.fifo_w_data = bus.data0;
        end else if (gnt_q[1]) begin
            bus.fifo_w_data = bus.data1;
        end else begin
            bus.fifo_w_data = '0;
        end
    end

    assign bus.ready0  = ready0;
    assign bus.ready1  = ready1;
    assign bus.fifo_wr = wr;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = |gnt_q;

    // Grant selection in IDLE, byte counting and burst release in BURST
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        pick     = 1'b0;
        len_pick = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    // on a tie the client that was not served last wins
                    pick     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
                    len_pick = pick ? bus.len1 : bus.len0;
                    gnt_d    = pick ? 2'b10 : 2'b01;
                    // a zero length still moves one byte
                    cnt_d    = (len_pick == '0) ? LEN_W'(1) : len_pick;
                    state_d  = ST_BURST;
                end
            end
            default: begin
                // counter only moves on an accepted byte, so it cannot underflow
                if (wr) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        gnt_d   = 2'b00;
                        last_d  = sel;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State registers; reset abandons any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule
